// File: rtl/shifter_pkg.sv
// Shared types for the iterative shifter: operation mode encodings and FSM states.
package shifter_pkg;

  typedef enum logic [1:0] {
    MODE_LOGICAL = 2'b00,
    MODE_ROTATE  = 2'b01,
    MODE_ARITH   = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational single step of the iterative shifter: shifts N bits by 0..stride
// places left or right with logical, rotate or sign fill.
module shift_step
  import shifter_pkg::*;
#(
  parameter int N  = 8,
  parameter int AW = $clog2(N)
) (
  input  logic [N-1:0]  i_value,
  input  logic [AW-1:0] i_step,
  input  logic          i_direction,
  input  mode_t         i_mode,
  input  logic          i_sign,
  output logic [N-1:0]  o_value
);

  logic [N-1:0] w_fill_l;
  logic [N-1:0] w_fill_r;

  // The fill word is concatenated beside the operand so one wide shift covers
  // zero fill, wrap-around and sign fill alike; reserved mode falls to logical.
  always_comb begin
    w_fill_l = '0;
    w_fill_r = '0;
    o_value  = '0;
    if (i_mode == MODE_ROTATE) begin
      w_fill_l = i_value;
      w_fill_r = i_value;
    end else if (i_mode == MODE_ARITH) begin
      w_fill_r = {N{i_sign}};
    end
    if (i_direction)
      o_value = N'(({i_value, w_fill_l} << i_step) >> N);
    else
      o_value = N'({w_fill_r, i_value} >> i_step);
  end

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle shifter/rotator: up to STRIDE bits per cycle, IDLE/RUN/DONE handshake.
// Define SHIFTER_ARITH_EN to enable arithmetic right shift (mode 10, sign fill).
module iterative_shifter
  import shifter_pkg::*;
#(
  parameter  int N      = 8,
  parameter  int STRIDE = 1,
  localparam int AW     = $clog2(N)
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic          i_direction,
  input  logic [1:0]    i_mode,
  input  logic [AW-1:0] i_amount,
  input  logic [N-1:0]  i_value,
  output logic          o_busy,
  output logic          o_done,
  output logic [N-1:0]  o_value
);

  // remaining never exceeds N-1, so a stride of N clamps to N-1 without loss.
  localparam int STEP_MAX = (STRIDE < N) ? STRIDE : N - 1;

  state_t        r_state;
  logic [AW-1:0] r_remaining;
  logic [N-1:0]  r_data;
  logic          r_direction;
  mode_t         r_mode;
  logic          r_busy;
  logic          r_done;

  logic [AW-1:0] w_step;
  logic [N-1:0]  w_next_data;
  mode_t         w_mode;
  logic          w_sign;

`ifdef SHIFTER_ARITH_EN
  logic r_sign;

  always_ff @(posedge i_clock) begin
    if (i_reset)
      r_sign <= 1'b0;
    else if (i_start && r_state != S_RUN)
      r_sign <= i_value[N-1];
  end

  assign w_sign = r_sign;
  assign w_mode = r_mode;
`else
  assign w_sign = 1'b0;
  assign w_mode = (r_mode == MODE_ARITH) ? MODE_LOGICAL : r_mode;
`endif

  assign w_step = (r_remaining > AW'(STEP_MAX)) ? AW'(STEP_MAX) : r_remaining;

  shift_step #(
    .N  (N),
    .AW (AW)
  ) u_shift_step (
    .i_value     (r_data),
    .i_step      (w_step),
    .i_direction (r_direction),
    .i_mode      (w_mode),
    .i_sign      (w_sign),
    .o_value     (w_next_data)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_data      <= '0;
      r_direction <= 1'b0;
      r_mode      <= MODE_LOGICAL;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_data      <= i_value;
            r_remaining <= i_amount;
            r_direction <= i_direction;
            r_mode      <= mode_t'(i_mode);
            if (i_amount == '0) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
            end
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        end
        S_RUN: begin
          r_data      <= w_next_data;
          r_remaining <= r_remaining - w_step;
          if (r_remaining == w_step) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_value = r_data;

endmodule

// File: tb/tb_iterative_shifter.sv
// Directed bench for iterative_shifter: two instances (STRIDE 1 and 4) share stimulus;
// a vector table covers the modes, hand sequences cover RUN-ignore, back-to-back and reset.
module tb_iterative_shifter;

  localparam int N  = 8;
  localparam int AW = 3;

  typedef struct {
    logic         dir;
    logic [1:0]   mode;
    int           amt;
    logic [N-1:0] val;
    logic [N-1:0] exp;
  } vec_t;

  logic          clk;
  logic          rst;
  logic          start;
  logic          dir;
  logic [1:0]    mode;
  logic [AW-1:0] amount;
  logic [N-1:0]  value;
  logic          busy1, done1, busy4, done4;
  logic [N-1:0]  val1, val4;

  int n_checks;
  int n_fail;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  iterative_shifter #(.N(N), .STRIDE(1)) u_dut1 (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_direction(dir),
    .i_mode(mode), .i_amount(amount), .i_value(value),
    .o_busy(busy1), .o_done(done1), .o_value(val1)
  );

  iterative_shifter #(.N(N), .STRIDE(4)) u_dut4 (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_direction(dir),
    .i_mode(mode), .i_amount(amount), .i_value(value),
    .o_busy(busy4), .o_done(done4), .o_value(val4)
  );

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lat(input int amt, input int stride);
    return (amt + stride - 1) / stride;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic d, input logic [1:0] m, input int a, input logic [N-1:0] v);
    start  = 1'b1;
    dir    = d;
    mode   = m;
    amount = AW'(a);
    value  = v;
  endtask

  task automatic run_vec(input int idx, input vec_t t);
    int l1, l4;
    l1 = lat(t.amt, 1);
    l4 = lat(t.amt, 4);
    @(negedge clk);
    drive(t.dir, t.mode, t.amt, t.val);
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      check($sformatf("v%0d c%0d busy1", idx, c), N'(busy1), N'(c <= l1));
      check($sformatf("v%0d c%0d done1", idx, c), N'(done1), N'(c == l1 + 1));
      check($sformatf("v%0d c%0d busy4", idx, c), N'(busy4), N'(c <= l4));
      check($sformatf("v%0d c%0d done4", idx, c), N'(done4), N'(c == l4 + 1));
      if (c == l1 + 1) check($sformatf("v%0d value1", idx), val1, t.exp);
      if (c == l4 + 1) check($sformatf("v%0d value4", idx), val4, t.exp);
      if (c < 9) @(negedge clk);
    end
  endtask

  vec_t vecs[10];

  // ---------------- test ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    dir      = 1'b0;
    mode     = 2'b00;
    amount   = '0;
    value    = '0;

    vecs[0] = '{1'b1, 2'b01, 3, 8'h96, 8'hB4};
    vecs[1] = '{1'b0, 2'b00, 5, 8'h96, 8'h04};
`ifdef SHIFTER_ARITH_EN
    vecs[2] = '{1'b0, 2'b10, 2, 8'h96, 8'hE5};
    vecs[8] = '{1'b0, 2'b10, 7, 8'h80, 8'hFF};
`else
    vecs[2] = '{1'b0, 2'b10, 2, 8'h96, 8'h25};
    vecs[8] = '{1'b0, 2'b10, 7, 8'h80, 8'h01};
`endif
    vecs[3] = '{1'b0, 2'b00, 0, 8'h3C, 8'h3C};
    vecs[4] = '{1'b1, 2'b00, 7, 8'hFF, 8'h80};
    vecs[5] = '{1'b0, 2'b01, 7, 8'h96, 8'h2D};
    vecs[6] = '{1'b1, 2'b10, 3, 8'h96, 8'hB0};
    vecs[7] = '{1'b0, 2'b11, 4, 8'h96, 8'h09};
    vecs[9] = '{1'b0, 2'b10, 3, 8'h70, 8'h0E};

    repeat (3) @(negedge clk);
    check("reset busy1", N'(busy1), 8'h00);
    check("reset done1", N'(done1), 8'h00);
    check("reset value1", val1, 8'h00);
    check("reset busy4", N'(busy4), 8'h00);
    check("reset done4", N'(done4), 8'h00);
    check("reset value4", val4, 8'h00);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Start ignored during RUN, then a back-to-back start in the DONE cycle.
    @(negedge clk);
    drive(1'b1, 2'b01, 7, 8'h01);
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      check($sformatf("b2b c%0d busy1", c), N'(busy1), N'((c >= 1 && c <= 7) || (c >= 9 && c <= 12)));
      check($sformatf("b2b c%0d done1", c), N'(done1), N'(c == 8 || c == 13));
      check($sformatf("b2b c%0d busy4", c), N'(busy4), N'((c >= 1 && c <= 2) || c == 9));
      check($sformatf("b2b c%0d done4", c), N'(done4), N'(c == 3 || c == 10));
      if (c == 8)  check("b2b first value1", val1, 8'h80);
      if (c == 3)  check("b2b first value4", val4, 8'h80);
      if (c == 13) check("b2b second value1", val1, 8'h0F);
      if (c == 10) check("b2b second value4", val4, 8'h0F);
      if (c == 2) drive(1'b0, 2'b00, 1, 8'hFF);
      if (c == 3) start = 1'b0;
      if (c == 8) drive(1'b0, 2'b00, 4, 8'hF0);
      if (c == 9) start = 1'b0;
      @(negedge clk);
    end

    // Reset in the middle of RUN aborts without a done pulse.
    drive(1'b1, 2'b00, 6, 8'h0F);
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 2) check("rst mid value1", val1, 8'h1E);
      if (c >= 3) begin
        check($sformatf("rst c%0d busy1", c), N'(busy1), 8'h00);
        check($sformatf("rst c%0d busy4", c), N'(busy4), 8'h00);
        check($sformatf("rst c%0d value1", c), val1, 8'h00);
        check($sformatf("rst c%0d value4", c), val4, 8'h00);
      end
      check($sformatf("rst c%0d done1", c), N'(done1), 8'h00);
      check($sformatf("rst c%0d done4", c), N'(done4), 8'h00);
      if (c == 2) rst = 1'b1;
      if (c == 3) rst = 1'b0;
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
